// File: rtl/tea_stream_driver.sv
// tea_stream_driver
// Host-side sequencer for one tea_interface core. It takes a 128-bit key and
// 64-bit blocks over valid/ready, runs the core's two-beat key load and
// write/wait protocol, and hands each result back over valid/ready. Only one
// block is in flight at a time, and the core's pin sharing is hidden from the host.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   key_valid/ready, key  key stream; key[127:64] goes to the core first
//   blk_valid/ready       block stream, with blk_mode (0 enc, 1 dec) and blk_data
//   res_valid/ready       result stream, with res_data and res_mode
//   key_loaded            the core holds a valid key
//   timeout_err           sticky; the core never raised out_ready
//   core_*                pins to and from the core
//
// state  | meaning
// -------+-------------------------------------------------------
// NOKEY  | no key in the core; waiting for a key handshake
// KEY_HI | core_reset high, upper key half on core_in
// KEY_LO | lower key half on core_in
// READY  | key loaded; accepts a new key or a block
// WRITE  | core_write high, block and mode on the core pins
// WAIT   | waiting for core_out_ready; timeout counter running
// OUT    | result held until res_ready

module tea_stream_driver #(
   parameter int CORE_CYCLES = 8,
   parameter int TIMEOUT     = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          key_valid,
   output logic          key_ready,
   input  logic [127:0]  key,
   input  logic          blk_valid,
   output logic          blk_ready,
   input  logic          blk_mode,
   input  logic [63:0]   blk_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [63:0]   res_data,
   output logic          res_mode,
   output logic          key_loaded,
   output logic          timeout_err,
   output logic [63:0]   core_in,
   output logic          core_mode,
   output logic          core_reset,
   output logic          core_write,
   input  logic [63:0]   core_out,
   input  logic          core_out_ready
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   // The WAIT window must be long enough for the core to finish a block.
   generate
      if (TIMEOUT <= CORE_CYCLES + 1) begin : g_bad_timeout
         $error("TIMEOUT must exceed CORE_CYCLES+1");
      end
   endgenerate

   typedef enum logic [2:0] {
      NOKEY, KEY_HI, KEY_LO, READY, WRITE, WAIT, OUT
   } state_t;

   state_t             state;
   logic [127:0]       key_q;
   logic [63:0]        blk_q;
   logic               mode_q;
   logic [CNT_W-1:0]   cnt;
   logic               blk_ready_q;

   // A key offered in READY takes priority over a block offered in the same
   // cycle, so blk_ready is pulled low combinationally while key_valid is high.
   assign blk_ready = blk_ready_q & ~key_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= NOKEY;
         key_q       <= '0;
         blk_q       <= '0;
         mode_q      <= 1'b0;
         cnt         <= '0;
         key_ready   <= 1'b0;
         blk_ready_q <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_mode    <= 1'b0;
         key_loaded  <= 1'b0;
         timeout_err <= 1'b0;
         core_in     <= '0;
         core_mode   <= 1'b0;
         core_reset  <= 1'b0;
         core_write  <= 1'b0;
      end else begin
         // Strobes and handshake readies are driven for one cycle at a time;
         // each branch re-asserts whatever the next state needs.
         key_ready   <= 1'b0;
         blk_ready_q <= 1'b0;
         core_reset  <= 1'b0;
         core_write  <= 1'b0;
         core_in     <= '0;

         unique case (state)
            NOKEY: begin
               if (key_valid && key_ready) begin
                  key_q      <= key;
                  core_reset <= 1'b1;
                  core_in    <= key[127:64];
                  state      <= KEY_HI;
               end else begin
                  key_ready <= 1'b1;
               end
            end

            KEY_HI: begin
               core_in <= key_q[63:0];
               state   <= KEY_LO;
            end

            KEY_LO: begin
               key_loaded  <= 1'b1;
               key_ready   <= 1'b1;
               blk_ready_q <= 1'b1;
               state       <= READY;
            end

            READY: begin
               if (key_valid && key_ready) begin
                  key_q      <= key;
                  key_loaded <= 1'b0;
                  core_reset <= 1'b1;
                  core_in    <= key[127:64];
                  state      <= KEY_HI;
               end else if (blk_valid && blk_ready) begin
                  blk_q      <= blk_data;
                  mode_q     <= blk_mode;
                  core_write <= 1'b1;
                  core_in    <= blk_data;
                  core_mode  <= blk_mode;
                  cnt        <= CNT_W'(TIMEOUT - 1);
                  state      <= WRITE;
               end else begin
                  key_ready   <= 1'b1;
                  blk_ready_q <= 1'b1;
               end
            end

            // The core's out_ready may still be high from the previous block
            // here; it is only trusted from WAIT onwards.
            WRITE: begin
               state <= WAIT;
            end

            WAIT: begin
               if (core_out_ready) begin
                  res_data  <= core_out;
                  res_mode  <= mode_q;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else if (cnt == '0) begin
                  timeout_err <= 1'b1;
                  key_loaded  <= 1'b0;
                  key_ready   <= 1'b1;
                  state       <= NOKEY;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            OUT: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  key_ready   <= 1'b1;
                  blk_ready_q <= 1'b1;
                  state       <= READY;
               end
            end

            default: begin
               state <= NOKEY;
            end
         endcase
      end
   end

   // blk_q holds the accepted block for the whole transaction; it only drives
   // the core pins in the WRITE cycle, which are loaded straight from blk_data.
   logic unused_blk;
   assign unused_blk = ^blk_q;

endmodule

// File: tb/tb_tea_stream_driver.sv
// tb_tea_stream_driver
// Directed bench for tea_stream_driver. A behavioural stand-in for the
// tea_interface core (32 rounds, 4 per clock, no byte swap) sits on the core
// pins and computes results with a reference TEA function.

module tb_tea_stream_driver;

   localparam int CORE_CYCLES = 8;
   localparam int TIMEOUT     = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key_valid = 1'b0;
   logic          key_ready;
   logic [127:0]  key = '0;
   logic          blk_valid = 1'b0;
   logic          blk_ready;
   logic          blk_mode = 1'b0;
   logic [63:0]   blk_data = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [63:0]   res_data;
   logic          res_mode;
   logic          key_loaded;
   logic          timeout_err;
   logic [63:0]   core_in;
   logic          core_mode;
   logic          core_reset;
   logic          core_write;
   logic [63:0]   core_out;
   logic          core_out_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tea_stream_driver #(.CORE_CYCLES(CORE_CYCLES), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .reset          (reset),
      .key_valid      (key_valid),
      .key_ready      (key_ready),
      .key            (key),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .blk_mode       (blk_mode),
      .blk_data       (blk_data),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_mode       (res_mode),
      .key_loaded     (key_loaded),
      .timeout_err    (timeout_err),
      .core_in        (core_in),
      .core_mode      (core_mode),
      .core_reset     (core_reset),
      .core_write     (core_write),
      .core_out       (core_out),
      .core_out_ready (core_out_ready)
   );

   function automatic logic [63:0] tea(input logic [127:0] k, input logic [63:0] d,
                                       input logic dec);
      logic [31:0] v0, v1, s, k0, k1, k2, k3;
      v0 = d[63:32];
      v1 = d[31:0];
      k0 = k[127:96];
      k1 = k[95:64];
      k2 = k[63:32];
      k3 = k[31:0];
      if (!dec) begin
         s = 32'h0;
         for (int r = 0; r < 32; r++) begin
            s  = s + 32'h9e3779b9;
            v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
            v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
         end
      end else begin
         s = 32'hc6ef3720;
         for (int r = 0; r < 32; r++) begin
            v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
            v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
            s  = s - 32'h9e3779b9;
         end
      end
      return {v0, v1};
   endfunction

   // Core stand-in: upper key half while core_reset is high, lower half on the
   // following clock; out_ready rises CORE_CYCLES+1 clocks after core_write.
   logic [127:0] c_key  = '0;
   logic         c_pend = 1'b0;
   logic [63:0]  c_blk  = '0;
   logic         c_mode = 1'b0;
   int           c_cnt  = 0;
   logic         c_rdy  = 1'b0;
   logic [63:0]  c_out  = '0;
   logic         stall  = 1'b0;

   assign core_out       = c_out;
   assign core_out_ready = c_rdy & ~stall;

   always @(posedge clk) begin
      if (core_reset) begin
         c_key[127:64] <= core_in;
         c_pend        <= 1'b1;
      end else if (c_pend) begin
         c_key[63:0] <= core_in;
         c_pend      <= 1'b0;
      end
      if (core_write) begin
         c_blk  <= core_in;
         c_mode <= core_mode;
         c_cnt  <= CORE_CYCLES + 1;
         c_rdy  <= 1'b0;
      end else if (c_cnt != 0) begin
         c_cnt <= c_cnt - 1;
         if (c_cnt == 1) begin
            c_rdy <= 1'b1;
            c_out <= tea(c_key, c_blk, c_mode);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic send_key(input logic [127:0] k);
      int n = 0;
      @(negedge clk);
      key = k;
      key_valid = 1'b1;
      while (!key_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("key_accept", key_ready, 1);
      @(posedge clk);
      #1 key_valid = 1'b0;
   endtask

   task automatic send_blk(input logic m, input logic [63:0] d);
      int n = 0;
      @(negedge clk);
      blk_mode = m;
      blk_data = d;
      blk_valid = 1'b1;
      while (!blk_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("blk_accept", blk_ready, 1);
      @(posedge clk);
      #1 blk_valid = 1'b0;
   endtask

   task automatic wait_res();
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 80) begin
         @(negedge clk);
         n++;
      end
      check_eq("res_wait", res_valid, 1);
   endtask

   task automatic take_res(input string tag, input logic [63:0] exp_d, input logic exp_m);
      wait_res();
      check_eq({tag, "_data"}, res_data, exp_d);
      check_eq({tag, "_mode"}, res_mode, exp_m);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k4;
      logic [63:0]  b3, b4, b6, d3;

      k4 = 128'h00112233_44556677_8899aabb_ccddeeff;
      b3 = 64'h01234567_89abcdef;
      b4 = 64'hfedcba98_76543210;
      b6 = 64'hdeadbeef_cafef00d;

      // Reset state
      #1;
      check_eq("rst_outputs",
               {key_ready, blk_ready, res_valid, res_mode, key_loaded, timeout_err,
                core_mode, core_reset, core_write},
               9'b0);
      check_eq("rst_core_in", core_in, 0);
      check_eq("rst_res_data", res_data, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: zero key, encrypt zero block, latency
      send_key(128'h0);
      send_blk(1'b0, 64'h0);
      repeat (10) @(posedge clk);
      #1 check_eq("lat_e10_low", res_valid, 0);
      @(posedge clk);
      #1 check_eq("lat_e11_high", res_valid, 1);
      check_eq("key_loaded_1", key_loaded, 1);
      take_res("enc0", 64'h41ea3a0a94baa940, 1'b0);

      // 2: decrypt it back
      send_blk(1'b1, 64'h41ea3a0a94baa940);
      take_res("dec0", 64'h0, 1'b1);

      // 3: backpressure on the result
      send_blk(1'b0, b3);
      wait_res();
      d3 = tea(128'h0, b3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_data", res_data, d3);
         check_eq("bp_valid", res_valid, 1);
         check_eq("bp_blk_ready", blk_ready, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      check_eq("bp_released", res_valid, 0);
      check_eq("bp_blk_ready_after", blk_ready, 1);

      // 4: key and block offered together
      @(negedge clk);
      key = k4;
      key_valid = 1'b1;
      blk_mode = 1'b0;
      blk_data = b4;
      blk_valid = 1'b1;
      #1;
      check_eq("kb_blk_ready_low", blk_ready, 0);
      check_eq("kb_key_ready", key_ready, 1);
      @(posedge clk);
      #1 key_valid = 1'b0;
      check_eq("kb_core_reset_hi", core_reset, 1);
      check_eq("kb_core_in_hi", core_in, k4[127:64]);
      @(posedge clk);
      #1 check_eq("kb_core_reset_lo", core_reset, 0);
      check_eq("kb_core_in_lo", core_in, k4[63:0]);
      @(posedge clk);
      #1 check_eq("kb_blk_ready_ready", blk_ready, 1);
      @(posedge clk);
      #1 blk_valid = 1'b0;
      check_eq("kb_core_write", core_write, 1);
      check_eq("kb_core_in_blk", core_in, b4);
      take_res("kb", tea(k4, b4, 1'b0), 1'b0);

      // 5: core never answers
      stall = 1'b1;
      send_blk(1'b0, b3);
      repeat (32) @(posedge clk);
      #1 check_eq("to_not_yet", timeout_err, 0);
      @(posedge clk);
      #1 check_eq("to_err", timeout_err, 1);
      check_eq("to_key_loaded", key_loaded, 0);
      check_eq("to_blk_ready", blk_ready, 0);
      check_eq("to_res_valid", res_valid, 0);
      stall = 1'b0;
      @(negedge clk);
      check_eq("to_key_ready", key_ready, 1);
      check_eq("to_sticky", timeout_err, 1);

      // 6: reset in WAIT
      send_key(k4);
      send_blk(1'b1, b6);
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check_eq("ar_outputs",
               {key_ready, blk_ready, res_valid, key_loaded, timeout_err,
                core_mode, core_reset, core_write},
               8'b0);
      check_eq("ar_core_in", core_in, 0);
      @(negedge clk);
      reset = 1'b0;
      blk_mode = 1'b1;
      blk_data = b6;
      blk_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("ar_blk_ignored", blk_ready, 0);
      end
      blk_valid = 1'b0;
      send_key(k4);
      send_blk(1'b1, b6);
      take_res("ar", tea(k4, b6, 1'b1), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
